// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and FSM state encoding for the ALU issue controller
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU-side and result signals of the ALU issue controller
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [OP_W-1:0]   in_op;
   logic              in_cin;
   logic              in_bin;
   logic              in_use_acc;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_select;
   logic              alu_cin;
   logic              alu_bin;
   logic [DATA_W-1:0] alu_out;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [OP_W-1:0]   res_op;

   // slave is the controller; master is the requester/ALU/consumer side around it
   modport slave (
      input  in_valid, in_a, in_b, in_op, in_cin, in_bin, in_use_acc, alu_out, res_ready,
      output in_ready, alu_a, alu_b, alu_select, alu_cin, alu_bin, res_valid, res_data, res_op
   );

   modport master (
      output in_valid, in_a, in_b, in_op, in_cin, in_bin, in_use_acc, alu_out, res_ready,
      input  in_ready, alu_a, alu_b, alu_select, alu_cin, alu_bin, res_valid, res_data, res_op
   );

endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - registers operands into an external ALU8, waits SETTLE_CYCLES, captures the result
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_issue_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic [OP_W-1:0]   alu_select_q;
   logic              alu_cin_q;
   logic              alu_bin_q;
   logic [DATA_W-1:0] res_data_q;
   logic [OP_W-1:0]   res_op_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_select_q <= '0;
         alu_cin_q    <= 1'b0;
         alu_bin_q    <= 1'b0;
         res_data_q   <= '0;
         res_op_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  alu_a_q      <= bus.in_use_acc ? acc_q : bus.in_a;
                  alu_b_q      <= bus.in_b;
                  alu_select_q <= bus.in_op;
                  alu_cin_q    <= bus.in_cin;
                  alu_bin_q    <= bus.in_bin;
                  cnt_q        <= CNT_LOAD;
                  state_q      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // counter reaching zero marks the final settle cycle
               if (cnt_q == '0) begin
                  res_data_q <= bus.alu_out;
                  res_op_q   <= alu_select_q;
                  acc_q      <= bus.alu_out;
                  state_q    <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.res_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == ST_IDLE);
   assign bus.res_valid  = (state_q == ST_HOLD);
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_select = alu_select_q;
   assign bus.alu_cin    = alu_cin_q;
   assign bus.alu_bin    = alu_bin_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_op     = res_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with SETTLE_CYCLES 1 and 4
module tb_alu_issue_ctrl;

   logic clk;
   logic rst1_n;
   logic rst4_n;
   int   total;
   int   bad;

   alu_issue_ctrl_if i1 ();
   alu_issue_ctrl_if i4 ();

   // ALU8 stub: A + B + carry-in
   assign i1.alu_out = i1.alu_a + i1.alu_b + {7'd0, i1.alu_cin};
   assign i4.alu_out = i4.alu_a + i4.alu_b + {7'd0, i4.alu_cin};

   alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(i1.slave));
   alu_issue_ctrl #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(i4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst1_n = 1'b0;
      rst4_n = 1'b0;
      i1.in_valid = 1'b1; i1.in_a = 8'h77; i1.in_b = 8'h11; i1.in_op = 4'h5;
      i1.in_cin = 1'b1; i1.in_bin = 1'b1; i1.in_use_acc = 1'b0; i1.res_ready = 1'b1;
      i4.in_valid = 1'b0; i4.in_a = 8'h00; i4.in_b = 8'h00; i4.in_op = 4'h0;
      i4.in_cin = 1'b0; i4.in_bin = 1'b0; i4.in_use_acc = 1'b0; i4.res_ready = 1'b1;

      // reset wins over a simultaneous request
      step();
      step();
      check("rst_in_ready", 32'(i1.in_ready), 32'd1);
      check("rst_res_valid", 32'(i1.res_valid), 32'd0);
      check("rst_alu_a", 32'(i1.alu_a), 32'd0);
      check("rst_alu_sel", 32'(i1.alu_select), 32'd0);
      check("rst4_in_ready", 32'(i4.in_ready), 32'd1);
      rst1_n = 1'b1;
      rst4_n = 1'b1;
      i1.in_valid = 1'b0;
      i1.res_ready = 1'b0;
      step();
      check("idle_hold_alu_a", 32'(i1.alu_a), 32'd0);

      // basic issue, SETTLE_CYCLES=1
      i1.in_a = 8'd9; i1.in_b = 8'd3; i1.in_op = 4'd1; i1.in_cin = 1'b1; i1.in_bin = 1'b0;
      i1.in_valid = 1'b1;
      step();
      i1.in_valid = 1'b0;
      check("acc1_alu_a", 32'(i1.alu_a), 32'd9);
      check("acc1_alu_b", 32'(i1.alu_b), 32'd3);
      check("acc1_alu_sel", 32'(i1.alu_select), 32'd1);
      check("acc1_alu_cin", 32'(i1.alu_cin), 32'd1);
      check("acc1_in_ready", 32'(i1.in_ready), 32'd0);
      check("acc1_res_valid", 32'(i1.res_valid), 32'd0);
      step();
      check("res1_valid", 32'(i1.res_valid), 32'd1);
      check("res1_data", 32'(i1.res_data), 32'd13);
      check("res1_op", 32'(i1.res_op), 32'd1);

      // backpressure with ignored requests
      i1.in_valid = 1'b1; i1.in_a = 8'h55; i1.in_b = 8'h44; i1.in_op = 4'd9;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_res_valid", 32'(i1.res_valid), 32'd1);
         check("bp_res_data", 32'(i1.res_data), 32'd13);
         check("bp_in_ready", 32'(i1.in_ready), 32'd0);
         check("bp_alu_a", 32'(i1.alu_a), 32'd9);
         check("bp_alu_sel", 32'(i1.alu_select), 32'd1);
      end
      i1.res_ready = 1'b1;
      step();
      i1.in_valid = 1'b0;
      i1.res_ready = 1'b0;
      check("drain_in_ready", 32'(i1.in_ready), 32'd1);
      check("drain_res_valid", 32'(i1.res_valid), 32'd0);
      check("drain_res_data", 32'(i1.res_data), 32'd13);

      // accumulator as A operand
      i1.in_use_acc = 1'b1; i1.in_a = 8'hFF; i1.in_b = 8'd3; i1.in_cin = 1'b0; i1.in_op = 4'd2;
      i1.in_valid = 1'b1;
      step();
      i1.in_valid = 1'b0;
      check("useacc_alu_a", 32'(i1.alu_a), 32'd13);
      check("useacc_alu_b", 32'(i1.alu_b), 32'd3);
      step();
      check("useacc_res_data", 32'(i1.res_data), 32'd16);
      check("useacc_res_op", 32'(i1.res_op), 32'd2);

      // reset during HOLD
      step();
      check("hold_stays", 32'(i1.res_valid), 32'd1);
      rst1_n = 1'b0;
      step();
      check("hrst_res_valid", 32'(i1.res_valid), 32'd0);
      step();
      rst1_n = 1'b1;
      check("hrst_in_ready", 32'(i1.in_ready), 32'd1);
      check("hrst_res_data", 32'(i1.res_data), 32'd0);
      check("hrst_res_op", 32'(i1.res_op), 32'd0);
      check("hrst_alu_a", 32'(i1.alu_a), 32'd0);
      check("hrst_alu_b", 32'(i1.alu_b), 32'd0);
      check("hrst_alu_sel", 32'(i1.alu_select), 32'd0);
      check("hrst_alu_cin", 32'(i1.alu_cin), 32'd0);
      check("hrst_alu_bin", 32'(i1.alu_bin), 32'd0);

      // accumulator cleared by reset; borrow-in passes through
      i1.in_use_acc = 1'b1; i1.in_a = 8'hFF; i1.in_b = 8'd5; i1.in_cin = 1'b0; i1.in_bin = 1'b1;
      i1.in_valid = 1'b1;
      step();
      i1.in_valid = 1'b0;
      check("acc0_alu_a", 32'(i1.alu_a), 32'd0);
      check("acc0_alu_bin", 32'(i1.alu_bin), 32'd1);
      step();
      check("acc0_res_data", 32'(i1.res_data), 32'd5);
      i1.res_ready = 1'b1;
      step();

      // SETTLE_CYCLES=4 latency
      i4.in_a = 8'd2; i4.in_b = 8'd5; i4.in_cin = 1'b1; i4.in_op = 4'd7; i4.in_use_acc = 1'b0;
      i4.in_valid = 1'b1;
      step();
      i4.in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check("s4_early_valid", 32'(i4.res_valid), 32'd0);
         step();
      end
      check("s4_early_valid", 32'(i4.res_valid), 32'd0);
      step();
      check("s4_valid", 32'(i4.res_valid), 32'd1);
      check("s4_data", 32'(i4.res_data), 32'd8);
      check("s4_op", 32'(i4.res_op), 32'd7);
      step();
      check("s4_idle", 32'(i4.in_ready), 32'd1);

      // reset in the second settle cycle discards the operation
      i4.in_use_acc = 1'b1; i4.in_b = 8'd1; i4.in_cin = 1'b0;
      i4.in_valid = 1'b1;
      step();
      i4.in_valid = 1'b0;
      check("s4_acc_alu_a", 32'(i4.alu_a), 32'd8);
      step();
      rst4_n = 1'b0;
      step();
      rst4_n = 1'b1;
      check("s4rst_in_ready", 32'(i4.in_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         check("s4rst_no_valid", 32'(i4.res_valid), 32'd0);
         step();
      end
      i4.in_use_acc = 1'b1; i4.in_b = 8'd0; i4.in_cin = 1'b0;
      i4.in_valid = 1'b1;
      step();
      i4.in_valid = 1'b0;
      check("s4rst_acc_zero", 32'(i4.alu_a), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, ALU settle cycles between operand drive and result capture; legal range 1..15.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted when high with in_valid at a clk edge.
REQ-007 in_a, in_b  input  8 each  operands.
REQ-008 in_op  input  4  ALU select code, passed through unmodified.
REQ-009 in_cin, in_bin  input  1 each  carry-in / borrow-in.
REQ-010 in_use_acc  input  1  when high, accumulator replaces in_a as A operand.
REQ-011 alu_a, alu_b  output  8 each  registered operands to ALU8 A/B.
REQ-012 alu_select  output  4  registered select to ALU8.
REQ-013 alu_cin, alu_bin  output  1 each  registered carry/borrow to ALU8.
REQ-014 alu_out  input  8  combinational ALU8 result.
REQ-015 res_valid  output  1  result valid.
REQ-016 res_ready  input  1  downstream accepts result.
REQ-017 res_data  output  8  captured alu_out.
REQ-018 res_op  output  4  select code that produced res_data.

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-020 in_ready SHALL equal (state==IDLE), combinationally; no other state accepts requests.
REQ-021 IDLE, in_valid=1 at edge: SHALL load alu_a (acc if in_use_acc else in_a), alu_b, alu_select, alu_cin, alu_bin; load settle counter; go SETTLE.
REQ-022 IDLE, in_valid=0: SHALL hold all registers.
REQ-023 SETTLE SHALL last exactly SETTLE_CYCLES cycles; at edge ending its last cycle SHALL capture res_data<=alu_out, res_op<=alu_select, acc<=alu_out, go HOLD.
REQ-024 Latency: res_valid SHALL rise exactly SETTLE_CYCLES cycles after accepting edge.
REQ-025 res_valid SHALL equal (state==HOLD).
REQ-026 HOLD, res_ready=1 at edge: SHALL go IDLE; res_ready=0: SHALL stay HOLD, res_data/res_op stable.
REQ-027 alu_* outputs SHALL hold last values outside accept edges (stable through SETTLE and HOLD).
REQ-028 Accumulator: 8-bit register, written only on capture; wrap-around is whatever ALU8 produces, no saturation.
REQ-029 in_valid activity outside IDLE SHALL be ignored with no state change.
REQ-030 Settle counter 4 bits; SHALL not wrap for legal SETTLE_CYCLES.

Reset
REQ-031 rst_n=0 at edge SHALL force state IDLE from any state, discarding in-flight operation.
REQ-032 Reset SHALL clear alu_a, alu_b, alu_select, alu_cin, alu_bin, res_data, res_op, acc, counter to 0; res_valid=0, in_ready=1 after the reset edge.
REQ-033 Reset SHALL take priority over every simultaneous handshake.

Structure
REQ-034 Shared package alu_pkg SHALL hold DATA_W=8, OP_W=4, and the FSM state enum.
REQ-035 Single module; no sub-module; ALU8 instantiated by the parent, not inside this block.

Verification (bench ALU stub: alu_out = alu_a + alu_b + alu_cin)
REQ-036 rst_n=0 for 2 cycles during HOLD -> next cycle all outputs 0, in_ready=1, res_valid=0.
REQ-037 SETTLE_CYCLES=1, accept in_a=9, in_b=3, in_op=1, in_cin=1 -> next cycle alu_a=9, alu_b=3, alu_select=1; one cycle later res_valid=1, res_data=13, res_op=1.
REQ-038 res_ready=0 for 5 cycles with in_valid=1 -> res_valid=1, res_data=13 held, in_ready=0, alu_* unchanged; res_ready=1 -> IDLE next cycle.
REQ-039 After acc=13, accept in_use_acc=1, in_a=0xFF, in_b=3, in_cin=0 -> alu_a=13, res_data=16.
REQ-040 SETTLE_CYCLES=4 -> res_valid rises exactly 4 cycles after accepting edge; rst_n=0 during 2nd SETTLE cycle -> res_valid never asserts, acc=0.
